// File: rtl/proc_pkg.sv
// Shared definitions for the execute unit: opcodes, instruction field
// positions, FSM state encoding and condition-flag bit indices.
// No ports (package).
package proc_pkg;

    // Opcode values carried in instr[31:27].
    localparam logic [4:0] OP_MOVSGPR = 5'b00000;
    localparam logic [4:0] OP_MOV     = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00010;
    localparam logic [4:0] OP_SUB     = 5'b00011;
    localparam logic [4:0] OP_MUL     = 5'b00100;
    localparam logic [4:0] OP_AND     = 5'b00101;
    localparam logic [4:0] OP_OR      = 5'b00110;
    localparam logic [4:0] OP_XOR     = 5'b00111;
    localparam logic [4:0] OP_NOT     = 5'b01000;

    // Instruction field bit positions. imm overlaps rsrc2; mode picks which applies.
    localparam int OPER_MSB  = 31;
    localparam int OPER_LSB  = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int MODE_BIT  = 16;
    localparam int RSRC2_MSB = 15;
    localparam int RSRC2_LSB = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } execState_e;

    // Position of each condition flag inside the 4-bit flags word.
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/proc_iter_mul.sv
// Iterative radix-2 shift-add unsigned multiplier.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (aborts a multiply)
//   start_i     - load operands and begin; DATA_WIDTH cycles follow
//   opA_i/opB_i - multiplicand / multiplier, sampled on start_i
//   product_o   - full 2*DATA_WIDTH product; valid while done_o is high
//   done_o      - high during the last iteration cycle
module proc_iter_mul #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   opA_i,
    input  logic [DATA_WIDTH-1:0]   opB_i,
    output logic [2*DATA_WIDTH-1:0] product_o,
    output logic                    done_o
);
    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   mcand_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH:0]     partial;
    logic [CW-1:0]           count_q;
    logic                    busy_q;

    // The accumulator holds {partial product, remaining multiplier bits}.
    // Each step adds the multiplicand into the upper half when the current
    // multiplier bit is set, then shifts the whole thing right by one.
    // product_o is the post-step value so the caller can write it in the
    // final cycle rather than one cycle later.
    always_comb begin
        partial = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d   = {partial, acc_q[DATA_WIDTH-1:1]};
    end

    assign product_o = acc_d;
    assign done_o    = busy_q && (count_q == CW'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            mcand_q <= opA_i;
            acc_q   <= {{DATA_WIDTH{1'b0}}, opB_i};
            count_q <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            acc_q   <= acc_d;
            count_q <= count_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/proc_exec_unit.sv
// Execute unit: GPR file, SGPR and a serialized IDLE/EXEC/MUL sequencer.
// Optional condition flags are built only when PROC_FLAGS_EN is defined.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - instruction handshake (in_ready high only in IDLE)
//   instr               - {oper, rdst, rsrc1, mode, rsrc2/imm16}
//   done / illegal      - one-cycle pulses in the write cycle
//   dbg_raddr/dbg_rdata - combinational GPR read-back (0 when out of range)
//   sgpr                - special register (upper half of mul product)
//   flags               - {sign, zero, carry, overflow}; 0 without PROC_FLAGS_EN
module proc_exec_unit
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_GPR    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  done,
    output logic                  illegal,
    input  logic [4:0]            dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic [DATA_WIDTH-1:0] sgpr,
    output logic [3:0]            flags
);
    localparam int IDXW = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

    execState_e              state_q, state_d;
    logic [31:0]             ir_q;
    logic [DATA_WIDTH-1:0]   gpr_q [NUM_GPR];
    logic [DATA_WIDTH-1:0]   sgpr_q;

    logic [4:0]              irOper, irRdst, irRsrc1, irRsrc2;
    logic                    irMode;
    logic [DATA_WIDTH-1:0]   irImm;
    logic [4:0]              inOper, inRsrc1, inRsrc2;
    logic                    inMode;
    logic [DATA_WIDTH-1:0]   inImm;

    logic [DATA_WIDTH-1:0]   rs1Val, rs2Val, opB, inRs1Val, inRs2Val;
    logic [DATA_WIDTH-1:0]   execResult;
    logic                    execLegal;
    logic                    accept, mulStart, mulDone;
    logic [2*DATA_WIDTH-1:0] mulProduct;
    logic                    gprWrEn, sgprWrEn;
    logic [DATA_WIDTH-1:0]   gprWrData;

    assign irOper  = ir_q[OPER_MSB:OPER_LSB];
    assign irRdst  = ir_q[RDST_MSB:RDST_LSB];
    assign irRsrc1 = ir_q[RSRC1_MSB:RSRC1_LSB];
    assign irMode  = ir_q[MODE_BIT];
    assign irRsrc2 = ir_q[RSRC2_MSB:RSRC2_LSB];
    assign irImm   = DATA_WIDTH'(ir_q[IMM_MSB:IMM_LSB]);

    // The multiplier captures its operands at accept time, so it reads the
    // register file through the incoming instruction rather than the IR.
    assign inOper  = instr[OPER_MSB:OPER_LSB];
    assign inRsrc1 = instr[RSRC1_MSB:RSRC1_LSB];
    assign inMode  = instr[MODE_BIT];
    assign inRsrc2 = instr[RSRC2_MSB:RSRC2_LSB];
    assign inImm   = DATA_WIDTH'(instr[IMM_MSB:IMM_LSB]);

    // Register file read ports; indices past NUM_GPR read as zero.
    always_comb begin
        dbg_rdata = '0;
        rs1Val    = '0;
        rs2Val    = '0;
        inRs1Val  = '0;
        inRs2Val  = '0;
        if (int'(dbg_raddr) < NUM_GPR) dbg_rdata = gpr_q[dbg_raddr[IDXW-1:0]];
        if (int'(irRsrc1) < NUM_GPR)   rs1Val    = gpr_q[irRsrc1[IDXW-1:0]];
        if (int'(irRsrc2) < NUM_GPR)   rs2Val    = gpr_q[irRsrc2[IDXW-1:0]];
        if (int'(inRsrc1) < NUM_GPR)   inRs1Val  = gpr_q[inRsrc1[IDXW-1:0]];
        if (int'(inRsrc2) < NUM_GPR)   inRs2Val  = gpr_q[inRsrc2[IDXW-1:0]];
    end

    assign opB = irMode ? irImm : rs2Val;

    // Single-cycle result from the IR; sources are the pre-write values.
    always_comb begin
        execResult = '0;
        execLegal  = 1'b1;
        case (irOper)
            OP_MOVSGPR: execResult = sgpr_q;
            OP_MOV:     execResult = irMode ? irImm : rs1Val;
            OP_ADD:     execResult = rs1Val + opB;
            OP_SUB:     execResult = rs1Val - opB;
            OP_AND:     execResult = rs1Val & opB;
            OP_OR:      execResult = rs1Val | opB;
            OP_XOR:     execResult = rs1Val ^ opB;
            OP_NOT:     execResult = ~rs1Val;
            default:    execLegal  = 1'b0;
        endcase
    end

    proc_iter_mul #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mulStart),
        .opA_i     (inRs1Val),
        .opB_i     (inMode ? inImm : inRs2Val),
        .product_o (mulProduct),
        .done_o    (mulDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (inOper == OP_MUL) ? MUL : EXEC;
            EXEC:    state_d = IDLE;
            MUL:     if (mulDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Illegal opcodes still pass through EXEC so done pulses, but nothing is written.
    always_comb begin
        in_ready  = (state_q == IDLE);
        accept    = in_ready && in_valid;
        mulStart  = accept && (inOper == OP_MUL);
        done      = (state_q == EXEC) || ((state_q == MUL) && mulDone);
        illegal   = (state_q == EXEC) && !execLegal;
        gprWrEn   = ((state_q == EXEC) && execLegal) || ((state_q == MUL) && mulDone);
        sgprWrEn  = (state_q == MUL) && mulDone;
        gprWrData = (state_q == MUL) ? mulProduct[DATA_WIDTH-1:0] : execResult;
    end

    // Writes to an rdst with no backing register simply match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= '0;
            sgpr_q <= '0;
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
        end else begin
            if (accept)   ir_q   <= instr;
            if (sgprWrEn) sgpr_q <= mulProduct[2*DATA_WIDTH-1:DATA_WIDTH];
            for (int i = 0; i < NUM_GPR; i++) begin
                if (gprWrEn && (irRdst == 5'(i))) gpr_q[i] <= gprWrData;
            end
        end
    end

    assign sgpr = sgpr_q;

`ifdef PROC_FLAGS_EN
    logic [3:0] flags_q, flags_d;

    // Carry/borrow are derived from unsigned compares instead of a wider adder.
    // For mul, sign and zero describe the full 2*DATA_WIDTH product.
    always_comb begin
        flags_d = flags_q;
        if (state_q == EXEC) begin
            case (irOper)
                OP_ADD: begin
                    flags_d[FLAG_S] = execResult[DATA_WIDTH-1];
                    flags_d[FLAG_Z] = (execResult == '0);
                    flags_d[FLAG_C] = (execResult < rs1Val);
                    flags_d[FLAG_V] = (rs1Val[DATA_WIDTH-1] == opB[DATA_WIDTH-1])
                                   && (execResult[DATA_WIDTH-1] != rs1Val[DATA_WIDTH-1]);
                end
                OP_SUB: begin
                    flags_d[FLAG_S] = execResult[DATA_WIDTH-1];
                    flags_d[FLAG_Z] = (execResult == '0);
                    flags_d[FLAG_C] = (rs1Val < opB);
                    flags_d[FLAG_V] = (rs1Val[DATA_WIDTH-1] != opB[DATA_WIDTH-1])
                                   && (execResult[DATA_WIDTH-1] != rs1Val[DATA_WIDTH-1]);
                end
                OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                    flags_d[FLAG_S] = execResult[DATA_WIDTH-1];
                    flags_d[FLAG_Z] = (execResult == '0);
                    flags_d[FLAG_C] = 1'b0;
                    flags_d[FLAG_V] = 1'b0;
                end
                default: flags_d = flags_q;
            endcase
        end else if ((state_q == MUL) && mulDone) begin
            flags_d[FLAG_S] = mulProduct[2*DATA_WIDTH-1];
            flags_d[FLAG_Z] = (mulProduct == '0);
            flags_d[FLAG_C] = |mulProduct[2*DATA_WIDTH-1:DATA_WIDTH];
            flags_d[FLAG_V] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_proc_exec_unit.sv
// Scoreboard bench for proc_exec_unit (DATA_WIDTH=16, NUM_GPR=8).
// The driver runs an arithmetic reference model at issue time and queues the
// expected response; a monitor checks each done pulse against the queue.
// Flag expectations follow PROC_FLAGS_EN.
module tb_proc_exec_unit;
    localparam int DW   = 16;
    localparam int NGPR = 8;
`ifdef PROC_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef struct {
        logic        ill;
        int          doneCyc;
        logic [4:0]  rd;
        logic [15:0] rdVal;
        logic [15:0] sg;
        logic [3:0]  fl;
    } expItem_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        done, illegal;
    logic [4:0]  dbg_raddr;
    logic [15:0] dbg_rdata, sgpr;
    logic [3:0]  flags;

    logic [4:0]  monIdx = '0;
    logic [4:0]  sweepIdx = '0;
    logic        sweepMode = 1'b0;
    logic        monBusy = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [15:0] mRegs [32];
    logic [15:0] mSgpr;
    logic [3:0]  mFlags;
    expItem_t    expQ [$];

    assign dbg_raddr = sweepMode ? sweepIdx : monIdx;

    proc_exec_unit #(.DATA_WIDTH(DW), .NUM_GPR(NGPR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .done(done), .illegal(illegal), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata), .sgpr(sgpr), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic m, input logic [15:0] low);
        return {op, rd, rs1, m, low};
    endfunction

    function automatic logic [15:0] mRead(input logic [4:0] idx);
        return (int'(idx) < NGPR) ? mRegs[idx] : 16'h0;
    endfunction

    function automatic logic [3:0] expFlags();
        return FLAGS_ON ? mFlags : 4'b0000;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 16'h0;
        mSgpr  = 16'h0;
        mFlags = 4'h0;
    endtask

    // Reference model: plain integer arithmetic on the architectural state.
    task automatic modelExec(input logic [31:0] ins, input int acceptCyc);
        logic [4:0]  op, rd, rs1, rs2;
        logic        m, wr, updFl;
        logic [15:0] imm, a, b, res;
        logic [3:0]  fl;
        int          ia, ib, sa, sb, r;
        longint      prod;
        expItem_t    e;
        op = ins[31:27]; rd = ins[26:22]; rs1 = ins[21:17]; m = ins[16];
        rs2 = ins[15:11]; imm = ins[15:0];
        a = mRead(rs1);
        b = m ? imm : mRead(rs2);
        ia = int'(a); ib = int'(b);
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        wr = 1'b1; updFl = 1'b0; fl = 4'b0; res = 16'h0; e.ill = 1'b0;
        case (int'(op))
            0: res = mSgpr;
            1: res = m ? imm : a;
            2: begin
                r = ia + ib; res = 16'(r % 65536); updFl = 1'b1;
                fl = {res >= 16'h8000, res == 16'h0, r >= 65536, (sa + sb > 32767) || (sa + sb < -32768)};
            end
            3: begin
                r = ia - ib; res = 16'((r + 65536) % 65536); updFl = 1'b1;
                fl = {res >= 16'h8000, res == 16'h0, ia < ib, (sa - sb > 32767) || (sa - sb < -32768)};
            end
            4: begin
                prod = longint'(ia) * longint'(ib);
                res = 16'(prod % 65536); mSgpr = 16'(prod / 65536); updFl = 1'b1;
                fl = {prod >= 64'sd2147483648, prod == 0, prod >= 65536, 1'b0};
            end
            5: begin res = a & b; updFl = 1'b1; fl = {res >= 16'h8000, res == 16'h0, 2'b00}; end
            6: begin res = a | b; updFl = 1'b1; fl = {res >= 16'h8000, res == 16'h0, 2'b00}; end
            7: begin res = a ^ b; updFl = 1'b1; fl = {res >= 16'h8000, res == 16'h0, 2'b00}; end
            8: begin res = ~a;    updFl = 1'b1; fl = {res >= 16'h8000, res == 16'h0, 2'b00}; end
            default: begin wr = 1'b0; e.ill = 1'b1; end
        endcase
        if (wr && int'(rd) < NGPR) mRegs[rd] = res;
        if (updFl) mFlags = fl;
        e.doneCyc = acceptCyc + ((int'(op) == 4) ? DW : 1);
        e.rd      = rd;
        e.rdVal   = mRead(rd);
        e.sg      = mSgpr;
        e.fl      = expFlags();
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input bit pushExp);
        int waitCnt = 0;
        @(negedge clk);
        while (!in_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
            return;
        end
        instr = ins;
        in_valid = 1'b1;
        if (pushExp) modelExec(ins, cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr = $urandom();
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((expQ.size() != 0 || monBusy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || monBusy) begin
            total++; bad++;
            $display("[TB] FAIL drain_timeout: got pending=%0d want 0", expQ.size());
            expQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkReg(input logic [4:0] idx, input logic [31:0] exp);
        sweepMode = 1'b1; sweepIdx = idx; #1;
        checkOutput($sformatf("reg_r%0d", idx), 32'(dbg_rdata), exp);
        sweepMode = 1'b0;
    endtask

    task automatic sweepRegs();
        sweepMode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sweepIdx = 5'(i); #1;
            checkOutput($sformatf("sweep_r%0d", i), 32'(dbg_rdata), 32'(mRead(5'(i))));
        end
        sweepMode = 1'b0;
        checkOutput("sweep_sgpr", 32'(sgpr), 32'(mSgpr));
        checkOutput("sweep_flags", 32'(flags), 32'(expFlags()));
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        expItem_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                monBusy = 1'b1;
                if (expQ.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_done: got done=1 want none (cycle %0d)", cyc);
                    monBusy = 1'b0;
                end else begin
                    e = expQ.pop_front();
                    checkOutput("illegal", 32'(illegal), 32'(e.ill));
                    checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
                    checkOutput("in_ready_busy", 32'(in_ready), 32'h0);
                    @(posedge clk); #1;
                    monIdx = e.rd; #1;
                    checkOutput("rdst_value", 32'(dbg_rdata), 32'(e.rdVal));
                    checkOutput("sgpr", 32'(sgpr), 32'(e.sg));
                    checkOutput("flags", 32'(flags), 32'(e.fl));
                    @(negedge clk);
                    checkOutput("in_ready_after", 32'(in_ready), 32'h1);
                    monBusy = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] rnd;
        modelReset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'h1);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_illegal", 32'(illegal), 32'h0);
        sweepRegs();

        $display("[TB] mov immediate");
        applyStimulus(enc(5'd1, 5'd1, 5'd0, 1'b1, 16'h1234), 1'b1);
        waitIdle();
        checkReg(5'd1, 32'h1234);
        sweepRegs();

        $display("[TB] add wrap to zero");
        applyStimulus(enc(5'd1, 5'd1, 5'd0, 1'b1, 16'hFFFF), 1'b1);
        applyStimulus(enc(5'd1, 5'd2, 5'd0, 1'b1, 16'h0001), 1'b1);
        applyStimulus(enc(5'd2, 5'd3, 5'd1, 1'b0, {5'd2, 11'd0}), 1'b1);
        waitIdle();
        checkReg(5'd3, 32'h0000);
        checkOutput("add_flags", 32'(flags), FLAGS_ON ? 32'h6 : 32'h0);

        $display("[TB] sub immediate with borrow");
        applyStimulus(enc(5'd1, 5'd1, 5'd0, 1'b1, 16'h0005), 1'b1);
        applyStimulus(enc(5'd3, 5'd4, 5'd1, 1'b1, 16'h0006), 1'b1);
        waitIdle();
        checkReg(5'd4, 32'hFFFF);
        checkOutput("sub_flags", 32'(flags), FLAGS_ON ? 32'hA : 32'h0);

        $display("[TB] multiply and movsgpr");
        applyStimulus(enc(5'd1, 5'd1, 5'd0, 1'b1, 16'h1234), 1'b1);
        applyStimulus(enc(5'd1, 5'd2, 5'd0, 1'b1, 16'h5678), 1'b1);
        applyStimulus(enc(5'd4, 5'd5, 5'd1, 1'b0, {5'd2, 11'd0}), 1'b1);
        applyStimulus(enc(5'd0, 5'd6, 5'd0, 1'b0, 16'h0), 1'b1);
        waitIdle();
        checkReg(5'd5, 32'h0060);
        checkReg(5'd6, 32'h0626);
        checkOutput("mul_sgpr", 32'(sgpr), 32'h0626);

        $display("[TB] reset during multiply");
        applyStimulus(enc(5'd4, 5'd5, 5'd1, 1'b0, {5'd2, 11'd0}), 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_done", 32'(done), 32'h0);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'h1);
        checkReg(5'd5, 32'h0000);
        checkOutput("abort_sgpr", 32'(sgpr), 32'h0);
        sweepRegs();
        applyStimulus(enc(5'd1, 5'd2, 5'd0, 1'b1, 16'h00AB), 1'b1);
        waitIdle();
        checkReg(5'd2, 32'h00AB);

        $display("[TB] illegal opcode and dropped write");
        applyStimulus(enc(5'b11111, 5'd2, 5'd2, 1'b1, 16'h5A5A), 1'b1);
        waitIdle();
        sweepRegs();
        applyStimulus(enc(5'd1, 5'd31, 5'd0, 1'b1, 16'hAAAA), 1'b1);
        waitIdle();
        checkReg(5'd31, 32'h0000);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 150; n++) begin
            op = 5'($urandom_range(0, 9));
            if (op == 5'd9) op = 5'($urandom_range(9, 31));
            rnd = $urandom();
            if ($urandom_range(0, 3) != 0) rnd[26:22] = 5'($urandom_range(0, NGPR - 1));
            if ($urandom_range(0, 3) != 0) rnd[21:17] = 5'($urandom_range(0, NGPR - 1));
            applyStimulus({op, rnd[26:0]}, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        waitIdle();
        sweepRegs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
